// File: rtl/switch_reader.sv
// Debounced switch/button reader: two-flop synchronizer and per-bit debounce
// counter feeding a stable-state register and sticky rising-edge flags.
module switch_reader #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rd_en,
    input  logic             wr_en,
    input  logic             addr,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] sw_port,
    output logic [WIDTH-1:0] data_out,
    output logic             irq
);

    localparam int unsigned CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] stable_next;
    logic [WIDTH-1:0] flags;
    logic [WIDTH-1:0] flags_next;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] clr;
    logic [CW-1:0]    cnt      [WIDTH];
    logic [CW-1:0]    cnt_next [WIDTH];

    always_comb begin
        stable_next = stable;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            cnt_next[i] = '0;
            if (sync2[i] != stable[i]) begin
                if (cnt[i] == CNT_MAX) begin
                    stable_next[i] = sync2[i];
                end else begin
                    cnt_next[i] = cnt[i] + CW'(1);
                end
            end
        end
    end

    // Set has priority over clear when both hit the same flag.
    always_comb begin
        rise       = stable_next & ~stable;
        clr        = (wr_en && addr) ? data_in : '0;
        flags_next = (flags & ~clr) | rise;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1  <= '0;
            sync2  <= '0;
            stable <= '0;
            flags  <= '0;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1  <= sw_port;
            sync2  <= sync1;
            stable <= stable_next;
            flags  <= flags_next;
            for (int unsigned i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end

    always_comb begin
        data_out = '0;
        if (rd_en) begin
            data_out = addr ? flags : stable;
        end
    end

    assign irq = |flags;

endmodule

// File: tb/tb_switch_reader.sv
// Directed bench for switch_reader (WIDTH=8, DB_CYCLES=4) with hand-computed
// expectations for debounce latency, bounce rejection, flag set/clear and reset.
module tb_switch_reader;

    logic       clk;
    logic       reset;
    logic       rd_en;
    logic       wr_en;
    logic       addr;
    logic [7:0] data_in;
    logic [7:0] sw_port;
    logic [7:0] data_out;
    logic       irq;

    int checks;
    int errors;

    switch_reader #(.WIDTH(8), .DB_CYCLES(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .rd_en    (rd_en),
        .wr_en    (wr_en),
        .addr     (addr),
        .data_in  (data_in),
        .sw_port  (sw_port),
        .data_out (data_out),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic a, input logic [7:0] exp, input string tag);
        rd_en = 1'b1;
        addr  = a;
        #1;
        check(tag, {24'd0, data_out}, {24'd0, exp});
    endtask

    task automatic wr(input logic a, input logic [7:0] d);
        wr_en   = 1'b1;
        addr    = a;
        data_in = d;
        tick(1);
        wr_en   = 1'b0;
        data_in = 8'h00;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        reset   = 1'b1;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        addr    = 1'b0;
        data_in = 8'h00;
        sw_port = 8'h00;
        tick(2);
        check("reset_dout_rd0", {24'd0, data_out}, 32'h0);
        check("reset_irq", {31'd0, irq}, 32'h0);
        rd(1'b0, 8'h00, "reset_stable");
        rd(1'b1, 8'h00, "reset_flags");
        rd_en = 1'b0;
        reset = 1'b0;
        tick(1);

        // Latency: captured at E0, stable after E5.
        sw_port = 8'h01;
        tick(5);
        rd(1'b0, 8'h00, "lat_stable_e4");
        tick(1);
        rd(1'b0, 8'h01, "lat_stable_e5");
        rd(1'b1, 8'h01, "lat_flag_e5");
        check("lat_irq_e5", {31'd0, irq}, 32'h1);
        wr(1'b1, 8'h01);
        rd(1'b1, 8'h00, "clr_flag0");
        check("clr_irq", {31'd0, irq}, 32'h0);

        // Bounce on bit 3, then a held press must take the full latency.
        sw_port = 8'h09;
        tick(3);
        sw_port = 8'h01;
        tick(8);
        rd(1'b0, 8'h01, "bounce_stable");
        rd(1'b1, 8'h00, "bounce_flags");
        sw_port = 8'h09;
        tick(5);
        rd(1'b0, 8'h01, "bounce_cnt_reset_e4");
        tick(1);
        rd(1'b0, 8'h09, "bounce_held_e5");
        rd(1'b1, 8'h08, "bounce_held_flag");

        // Build flags = 0x05.
        wr(1'b1, 8'h08);
        sw_port = 8'h08;
        tick(8);
        rd(1'b1, 8'h00, "fall_no_flag");
        sw_port = 8'h0D;
        tick(8);
        rd(1'b0, 8'h0D, "stable_0d");
        rd(1'b1, 8'h05, "flags_05");
        // Read-during-clear returns pre-clear flags.
        rd_en   = 1'b1;
        addr    = 1'b1;
        wr_en   = 1'b1;
        data_in = 8'h04;
        #1;
        check("rdwr_pre_clear", {24'd0, data_out}, 32'h05);
        tick(1);
        wr_en   = 1'b0;
        data_in = 8'h00;
        rd(1'b1, 8'h01, "clr04_flags");
        check("clr04_irq", {31'd0, irq}, 32'h1);
        wr(1'b1, 8'h01);
        rd(1'b1, 8'h00, "clr01_flags");
        check("clr01_irq", {31'd0, irq}, 32'h0);

        // Same-cycle set and clear on bit 2: set wins.
        sw_port = 8'h09;
        tick(8);
        rd(1'b0, 8'h09, "stable_09");
        sw_port = 8'h0D;
        tick(5);
        rd(1'b1, 8'h00, "setclr_pre");
        wr(1'b1, 8'h04);
        rd(1'b1, 8'h04, "setclr_set_wins");
        rd(1'b0, 8'h0D, "setclr_stable");
        wr(1'b1, 8'h04);
        rd(1'b1, 8'h00, "setclr_after_clr");

        // Read gating and addr=0 writes ignored.
        sw_port = 8'hFF;
        tick(8);
        rd_en = 1'b0;
        addr  = 1'b0;
        #1;
        check("rd0_zero", {24'd0, data_out}, 32'h0);
        rd(1'b0, 8'hFF, "stable_ff");
        wr(1'b0, 8'hFF);
        rd(1'b0, 8'hFF, "wr_addr0_stable");
        rd(1'b1, 8'hF2, "wr_addr0_flags");
        wr(1'b0, 8'h00);
        rd(1'b1, 8'hF2, "wr_addr0_zero_flags");

        // Reset mid-debounce, then re-debounce of a held input.
        sw_port = 8'h00;
        tick(8);
        wr(1'b1, 8'hFF);
        rd(1'b1, 8'h00, "pre_rst_flags");
        sw_port = 8'h80;
        tick(3);
        reset = 1'b1;
        tick(2);
        rd_en = 1'b0;
        #1;
        check("rst_mid_dout", {24'd0, data_out}, 32'h0);
        check("rst_mid_irq", {31'd0, irq}, 32'h0);
        rd(1'b0, 8'h00, "rst_mid_stable");
        rd(1'b1, 8'h00, "rst_mid_flags");
        reset = 1'b0;
        tick(5);
        rd(1'b0, 8'h00, "post_rst_e4");
        tick(1);
        rd(1'b0, 8'h80, "post_rst_e5");
        rd(1'b1, 8'h80, "post_rst_flag");
        check("post_rst_irq", {31'd0, irq}, 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/switch_reader.md
SWITCH_READER -- requirements
Module: switch_reader

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8: number of switch/button inputs and register width.
REQ-002 The module SHALL have parameter DB_CYCLES, default 4: consecutive stable cycles required to accept an input change (legal range 2..65535).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rd_en  input  1  read strobe; enables data_out.
REQ-006 wr_en  input  1  write strobe; used only for edge-flag clear.
REQ-007 addr  input  1  register select: 0 = debounced state, 1 = edge flags.
REQ-008 data_in  input  WIDTH  write data; for addr=1, bits set to 1 clear the matching edge flags.
REQ-009 sw_port  input  WIDTH  raw, asynchronous, possibly bouncing switch levels.
REQ-010 data_out  output  WIDTH  read data.
REQ-011 irq  output  1  high while any edge flag is set.

Function
REQ-012 Each sw_port bit SHALL pass through a two-flop synchronizer (sync1, then sync2) before any other use.
REQ-013 Each bit SHALL have an independent debounce counter of ceil(log2(DB_CYCLES)) bits and a stable-state flop.
REQ-014 When sync2 equals stable, the counter SHALL load 0.
REQ-015 When sync2 differs from stable and the counter is below DB_CYCLES-1, the counter SHALL increment by 1.
REQ-016 When sync2 differs from stable and the counter equals DB_CYCLES-1, stable SHALL load sync2 and the counter SHALL load 0.
REQ-017 Latency: a level first captured by sync1 at edge E0 and held SHALL appear on stable at edge E0+1+DB_CYCLES, and not earlier.
REQ-018 A change whose sync2 duration is shorter than DB_CYCLES cycles SHALL leave stable unchanged and return the counter to 0.
REQ-019 An edge-flag bit SHALL set on the edge at which its stable bit transitions 0->1; 1->0 transitions SHALL NOT set flags.
REQ-020 A write with wr_en=1 and addr=1 SHALL clear each edge flag whose data_in bit is 1; other flags SHALL hold.
REQ-021 If a set and a clear hit the same flag in the same cycle, the set SHALL win (flag = 1).
REQ-022 Writes with addr=0 SHALL have no effect.
REQ-023 data_out SHALL be combinational: stable when rd_en=1 and addr=0, edge flags when rd_en=1 and addr=1, all zeros when rd_en=0.
REQ-024 Simultaneous rd_en and wr_en to addr=1 SHALL return the pre-clear flags and apply the clear at the same edge.
REQ-025 irq SHALL be the combinational OR of all edge flags.

Reset
REQ-026 With reset=1 at a clock edge, sync1, sync2, stable, all counters and all edge flags SHALL load 0; this holds whether or not a debounce or write is in progress.
REQ-027 During and after reset, with rd_en=0, data_out SHALL be 0 and irq SHALL be 0.
REQ-028 An input already at 1 when reset deasserts SHALL be debounced per REQ-017 and SHALL set its edge flag.

Verification
REQ-029 DB_CYCLES=4: sw_port 0x00->0x01 held, first captured at E0 -> stable=0x00 through E4, 0x01 after E5; flag[0]=1 and irq=1 after E5.
REQ-030 Bounce: sw_port[3] high for 3 cycles, then low -> stable and flags remain 0x00; counter[3] returns to 0.
REQ-031 Flags=0x05; write addr=1, data_in=0x04 -> flags=0x01, irq=1; then write 0x01 -> flags=0x00, irq=0.
REQ-032 Same-cycle rising stable on bit 2 and clear of bit 2 -> flag[2]=1 afterwards.
REQ-033 rd_en=0 with stable=0xFF -> data_out=0x00; rd_en=1, addr=0 -> 0xFF; write addr=0, data_in=0x00 -> stable and flags unchanged.
REQ-034 reset=1 asserted mid-debounce, 2 cycles after a 0x00->0x80 change -> all state 0, irq=0; with sw_port held at 0x80 after release -> stable=0x80 at release-edge+1+DB_CYCLES.
